// File: rtl/lcd_line_filter.sv
// Horizontal 3-tap RGB filter (pass/blur/edge, greyscale on mode 3 when LCD_FILTER_GREY_EN is defined).
// Push 1 Clock after each capture; the output FIFO drops pushes when full and returns 0 when popped empty (both flags sticky).
module lcd_line_filter #(
  parameter int H_START    = 216,
  parameter int V_START    = 35,
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int PREFETCH   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Clock_en,
  input  logic        Enable,
  input  logic [10:0] H_Count,
  input  logic [9:0]  V_Count,
  input  logic [1:0]  Mode,
  output logic        oRead_in_en,
  input  logic [7:0]  R_in,
  input  logic [7:0]  G_in,
  input  logic [7:0]  B_in,
  input  logic        iRead_out_en,
  output logic [7:0]  R_out,
  output logic [7:0]  G_out,
  output logic [7:0]  B_out,
  output logic        oUnderflow,
  output logic        oOverflow
);
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

  localparam logic [10:0] L_H_FIRST = 11'(H_START - PREFETCH);
  localparam logic [10:0] L_H_LAST  = 11'(H_START - PREFETCH + H_PIXELS - 1);
  localparam logic [9:0]  L_V_FIRST = 10'(V_START);
  localparam logic [9:0]  L_V_LAST  = 10'(V_START + V_LINES - 1);
  localparam int          CW        = $clog2(H_PIXELS + 1);
  localparam logic [CW-1:0] L_NPIX  = CW'(H_PIXELS);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] L_FULL    = (AW+1)'(FIFO_DEPTH);

  state_t        r_state, w_state_nxt;
  logic          r_rd, r_cap, r_pend;
  logic [1:0]    r_mode;
  logic [CW-1:0] r_cnt;
  pix_t          r_l, r_c, r_r;
  pix_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_fcnt;
  logic          r_unf, r_ovf;

  logic w_win, w_req, w_line_start, w_push, w_use_self;
  logic w_empty, w_full, w_pop, w_wr;
  pix_t w_in, w_rr, w_res, w_head;

  assign w_win = (V_Count >= L_V_FIRST) && (V_Count <= L_V_LAST) &&
                 (H_Count >= L_H_FIRST) && (H_Count <= L_H_LAST);
  assign w_req        = Enable && Clock_en && w_win;
  assign w_line_start = w_req && (H_Count == L_H_FIRST);
  assign w_in         = '{r: R_in, g: G_in, b: B_in};

  // Request strobe, then a one-Clock delayed capture marker matching SDRAM FIFO latency.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_rd  <= 1'b0;
      r_cap <= 1'b0;
    end else begin
      r_rd  <= w_req;
      r_cap <= r_rd && Enable;
    end
  end

  assign oRead_in_en = r_rd;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_use_self  = 1'b0;
    if (!Enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_line_start) w_state_nxt = S_FILL;
        S_FILL:  if (r_cap) w_state_nxt = S_RUN;
        S_RUN: begin
          if (r_pend) begin
            w_push = 1'b1;
            if (r_cnt == L_NPIX) w_state_nxt = S_FLUSH;
          end
        end
        S_FLUSH: begin
          w_push      = 1'b1;
          w_use_self  = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Window {r_l, r_c, r_r}: r_r holds the newest capture until the push shifts it in.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_l <= '0; r_c <= '0; r_r <= '0;
      r_cnt <= '0; r_pend <= 1'b0; r_mode <= 2'd0;
    end else if (!Enable) begin
      r_l <= '0; r_c <= '0; r_r <= '0;
      r_cnt <= '0; r_pend <= 1'b0; r_mode <= 2'd0;
    end else begin
      if (Clock_en && (H_Count == 11'd0) && (V_Count == 10'd0)) r_mode <= Mode;
      r_pend <= 1'b0;
      if (r_state == S_FILL && r_cap) begin
        r_l   <= w_in;
        r_c   <= w_in;
        r_cnt <= CW'(1);
      end
      if (r_state == S_RUN && r_cap) begin
        r_r    <= w_in;
        r_pend <= 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
      if (r_state == S_RUN && r_pend) begin
        r_l <= r_c;
        r_c <= r_r;
      end
    end
  end

  function automatic logic [7:0] f_tap(input logic [1:0] m, input logic [7:0] l,
                                       input logic [7:0] c, input logic [7:0] r);
    case (m)
      2'd1:    f_tap = 8'(({2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + 10'd2) >> 2);
      2'd2:    f_tap = (r > l) ? (r - l) : (l - r);
      default: f_tap = c;
    endcase
  endfunction

  assign w_rr = w_use_self ? r_c : r_r;

  always_comb begin
    w_res.r = f_tap(r_mode, r_l.r, r_c.r, w_rr.r);
    w_res.g = f_tap(r_mode, r_l.g, r_c.g, w_rr.g);
    w_res.b = f_tap(r_mode, r_l.b, r_c.b, w_rr.b);
`ifdef LCD_FILTER_GREY_EN
    if (r_mode == 2'd3) begin
      w_res.r = 8'((16'd77 * {8'd0, r_c.r} + 16'd150 * {8'd0, r_c.g} +
                    16'd29 * {8'd0, r_c.b}) >> 8);
      w_res.g = w_res.r;
      w_res.b = w_res.r;
    end
`endif
  end

  assign w_empty = (r_fcnt == '0);
  assign w_full  = (r_fcnt == L_FULL);
  assign w_pop   = iRead_out_en && !w_empty;
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_wp <= '0; r_rp <= '0; r_fcnt <= '0;
      r_unf <= 1'b0; r_ovf <= 1'b0;
    end else begin
      if (iRead_out_en && w_empty) r_unf <= 1'b1;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      if (!Enable) begin
        r_wp <= '0; r_rp <= '0; r_fcnt <= '0;
      end else begin
        if (w_wr)  r_wp <= r_wp + 1'b1;
        if (w_pop) r_rp <= r_rp + 1'b1;
        r_fcnt <= r_fcnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (w_wr) r_mem[r_wp] <= w_res;
  end

  assign w_head     = w_empty ? '0 : r_mem[r_rp];
  assign R_out      = w_head.r;
  assign G_out      = w_head.g;
  assign B_out      = w_head.b;
  assign oUnderflow = r_unf;
  assign oOverflow  = r_ovf;
endmodule

// File: tb/tb_lcd_line_filter.sv
// Directed bench for lcd_line_filter: drives H/V counters per line, models the SDRAM read FIFO and pops the output FIFO.
module tb_lcd_line_filter;
  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Clock_en = 1'b0;
  logic        Enable = 1'b0;
  logic [10:0] H_Count = '0;
  logic [9:0]  V_Count = '0;
  logic [1:0]  Mode = 2'd0;
  logic        oRead_in_en;
  logic [7:0]  R_in = '0, G_in = '0, B_in = '0;
  logic        iRead_out_en = 1'b0;
  logic [7:0]  R_out, G_out, B_out;
  logic        oUnderflow, oOverflow;

  lcd_line_filter dut (
    .Clock(Clock), .Resetn(Resetn), .Clock_en(Clock_en), .Enable(Enable),
    .H_Count(H_Count), .V_Count(V_Count), .Mode(Mode),
    .oRead_in_en(oRead_in_en), .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .iRead_out_en(iRead_out_en), .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .oUnderflow(oUnderflow), .oOverflow(oOverflow)
  );

  always #5 Clock = ~Clock;

  int vectors = 0, miscompares = 0;
  int pr[640], pg[640], pb[640];
  int orr[640], og[640], ob[640];
  int n_req, n_pop;
  logic tb_en = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One Clock: inputs change on the falling edge, outputs sampled 1 time unit later.
  task automatic tick(input bit ce, input bit pop, input int h, input int v);
    @(negedge Clock);
    Enable = tb_en;
    Clock_en = ce;
    iRead_out_en = pop;
    H_Count = 11'(h);
    V_Count = 10'(v);
    if (oRead_in_en) begin
      if (n_req < 640) begin
        R_in = 8'(pr[n_req]); G_in = 8'(pg[n_req]); B_in = 8'(pb[n_req]);
      end
      n_req++;
    end
    #1;
    if (pop) begin
      if (n_pop < 640) begin
        orr[n_pop] = R_out; og[n_pop] = G_out; ob[n_pop] = B_out;
      end
      n_pop++;
    end
  endtask

  task automatic frame_start();
    tick(1'b1, 1'b0, 0, 0);
    tick(1'b0, 1'b0, 0, 0);
  endtask

  task automatic run_line(input bit pop_on, input int drop_h);
    n_req = 0;
    n_pop = 0;
    for (int h = 200; h <= 870; h++) begin
      if (h == drop_h) tb_en = 1'b0;
      tick(1'b1, pop_on && tb_en && h >= 216 && h <= 855, h, 35);
      tick(1'b0, 1'b0, h, 35);
      if (h == drop_h) begin
        check("t6_flush_head", int'(R_out), 0);
        check("t6_no_req", int'(oRead_in_en), 0);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Resetn = 1'b0;
    tb_en = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 0, 0);
    Resetn = 1'b1;
    tb_en = 1'b1;
    tick(1'b0, 1'b0, 0, 0);
  endtask

  task automatic load_ramp();
    for (int x = 0; x < 640; x++) begin
      pr[x] = x % 256; pg[x] = 255 - (x % 256); pb[x] = x / 4;
    end
  endtask

  task automatic load_spike();
    for (int x = 0; x < 640; x++) begin
      pr[x] = (x == 10) ? 200 : 100; pg[x] = pr[x]; pb[x] = pr[x];
    end
  endtask

  initial begin
    n_req = 0; n_pop = 0;
    do_reset();
    check("rst_read_en", int'(oRead_in_en), 0);
    check("rst_r_out", int'(R_out), 0);
    check("rst_g_out", int'(G_out), 0);
    check("rst_b_out", int'(B_out), 0);
    check("rst_underflow", int'(oUnderflow), 0);
    check("rst_overflow", int'(oOverflow), 0);

    // T1: pass-through ramp
    load_ramp();
    Mode = 2'd0; frame_start(); run_line(1'b1, -1);
    check("t1_reqs", n_req, 640);
    check("t1_pops", n_pop, 640);
    for (int x = 0; x < 640; x++) begin
      check($sformatf("t1_r[%0d]", x), orr[x], x % 256);
      check($sformatf("t1_g[%0d]", x), og[x], 255 - (x % 256));
      check($sformatf("t1_b[%0d]", x), ob[x], x / 4);
    end
    check("t1_underflow", int'(oUnderflow), 0);
    check("t1_overflow", int'(oOverflow), 0);

    // T2: blur of a single spike
    load_spike();
    Mode = 2'd1; frame_start(); run_line(1'b1, -1);
    check("t2_pops", n_pop, 640);
    for (int x = 0; x < 640; x++)
      check($sformatf("t2_r[%0d]", x), orr[x], (x == 10) ? 150 : (x == 9 || x == 11) ? 125 : 100);
    check("t2_g10", og[10], 150);
    check("t2_b11", ob[11], 125);

    // T3: edge detect on a step
    for (int x = 0; x < 640; x++) begin
      pr[x] = (x < 320) ? 0 : 255; pg[x] = pr[x]; pb[x] = pr[x];
    end
    Mode = 2'd2; frame_start(); run_line(1'b1, -1);
    check("t3_pops", n_pop, 640);
    for (int x = 0; x < 640; x++)
      check($sformatf("t3_r[%0d]", x), orr[x], (x == 319 || x == 320) ? 255 : 0);
    check("t3_b320", ob[320], 255);

    // T4: mode change only honoured at frame start
    load_spike();
    Mode = 2'd0; frame_start(); run_line(1'b1, -1);
    check("t4_m0_x10", orr[10], 200);
    check("t4_m0_x9", orr[9], 100);
    Mode = 2'd1; run_line(1'b1, -1);
    check("t4_mid_x10", orr[10], 200);
    check("t4_mid_x9", orr[9], 100);
    frame_start(); run_line(1'b1, -1);
    check("t4_new_x10", orr[10], 150);
    check("t4_new_x9", orr[9], 125);

    // T7: mode 3
`ifdef LCD_FILTER_GREY_EN
    for (int x = 0; x < 640; x++) begin pr[x] = 200; pg[x] = 200; pb[x] = 200; end
    Mode = 2'd3; frame_start(); run_line(1'b1, -1);
    for (int x = 0; x < 640; x += 213) begin
      check("t7_grey_r", orr[x], 200); check("t7_grey_g", og[x], 200); check("t7_grey_b", ob[x], 200);
    end
`else
    for (int x = 0; x < 640; x++) begin pr[x] = 10; pg[x] = 20; pb[x] = 30; end
    Mode = 2'd3; frame_start(); run_line(1'b1, -1);
    for (int x = 0; x < 640; x += 213) begin
      check("t7_pass_r", orr[x], 10); check("t7_pass_g", og[x], 20); check("t7_pass_b", ob[x], 30);
    end
`endif
    check("t7_pops", n_pop, 640);
    check("t7_underflow", int'(oUnderflow), 0);
    check("t7_overflow", int'(oOverflow), 0);

    // T5: overflow with no pops, then drain past empty
    load_ramp();
    Mode = 2'd0; frame_start(); run_line(1'b0, -1);
    check("t5_overflow", int'(oOverflow), 1);
    check("t5_underflow_pre", int'(oUnderflow), 0);
    n_pop = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("t5_underflow_at8", int'(oUnderflow), 0);
      tick(1'b1, 1'b1, 870, 35);
      tick(1'b0, 1'b0, 870, 35);
    end
    for (int i = 0; i < 8; i++) check($sformatf("t5_head[%0d]", i), orr[i], i);
    check("t5_pop9", orr[8], 0);
    check("t5_underflow", int'(oUnderflow), 1);

    // T6: Enable dropped mid-line, recovery on the next line
    do_reset();
    load_ramp();
    Mode = 2'd0; frame_start(); run_line(1'b1, 300);
    check("t6_partial_pops", n_pop, 84);
    check("t6_idle_head", int'(R_out), 0);
    tb_en = 1'b1;
    run_line(1'b1, -1);
    check("t6_reqs", n_req, 640);
    check("t6_pops", n_pop, 640);
    check("t6_x0", orr[0], 0);
    check("t6_x300", orr[300], 300 % 256);
    check("t6_x639", orr[639], 639 % 256);
    check("t6_underflow", int'(oUnderflow), 0);
    check("t6_overflow", int'(oOverflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
